// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl
// Load/store unit controller for the MEM stage. Accepts one RISC-V load or
// store per valid/ready handshake, validates it (funct3, alignment, address
// map), drives the data-memory op_code/rwaddr/wdata port stable for the
// memory latency, and returns a formatted load result. LBU/LHU are issued to
// the memory as word reads and extracted/zero-extended here.
//
// Ports
//   clk, nrst        clock, synchronous active-high reset
//   req_valid/ready  request handshake (ready only in IDLE, not in reset)
//   req_we           1 = store, 0 = load
//   req_funct3       RISC-V funct3
//   req_addr         14-bit byte address
//   req_wdata        store data, right-aligned
//   rsp_valid        one-cycle response pulse
//   rsp_rdata        load result (0 for stores and errors), held until next rsp
//   rsp_err          00 ok, 01 misaligned, 10 unmapped, 11 illegal funct3
//   busy             high while a request is in flight (pipeline stall)
//   mem_op           memory op_code (011 = idle)
//   mem_addr         memory rwaddr
//   mem_wdata        memory wdata (raw; memory does lane placement)
//   mem_stall        memory stall, 1 whenever no access is active
//   mem_rdata        memory read data
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int RD_LAT = 3,
    parameter int WR_LAT = 3
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [13:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_err,
    output logic        busy,
    output logic [2:0]  mem_op,
    output logic [13:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_stall,
    input  logic [31:0] mem_rdata
);

    localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_IDLE      = 3'b011;
    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_UNMAPPED = 2'b10;
    localparam logic [1:0] ERR_FUNCT3   = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ACCESS  = 2'b01,
        CAPTURE = 2'b10,
        RESP    = 2'b11
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic               accept;
    logic [1:0]         acc_err;

    logic               we_p0;
    logic [2:0]         funct3_p0;
    logic [13:0]        addr_p0;
    logic [31:0]        wdata_p0;

    // Checks in priority order: illegal funct3, then misalignment, then map.
    function automatic logic [1:0] check_req(input logic        we,
                                             input logic [2:0]  f3,
                                             input logic [13:0] addr);
        logic legal;
        logic misaligned;
        logic mapped;
        if (we)
            legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        else
            legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
        // f3[1:0] is the access size for every legal encoding (BU/HU included).
        misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                     ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        mapped     = (addr[11:10] == 2'b01) || (addr[11:10] == 2'b10);
        check_req  = !legal     ? ERR_FUNCT3   :
                     misaligned ? ERR_MISALIGN :
                     !mapped    ? ERR_UNMAPPED : ERR_OK;
    endfunction

    // LBU/LHU fall into the word-read encoding; extraction happens locally.
    function automatic logic [2:0] map_op(input logic we, input logic [2:0] f3);
        if (we) begin
            case (f3[1:0])
                2'b00:   map_op = 3'b100;
                2'b01:   map_op = 3'b101;
                default: map_op = 3'b111;
            endcase
        end else begin
            case (f3)
                3'b000:  map_op = 3'b000;
                3'b001:  map_op = 3'b001;
                default: map_op = 3'b010;
            endcase
        end
    endfunction

    function automatic logic [31:0] fmt_load(input logic [2:0]  f3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (lane)
            2'b00:   b = rdata[7:0];
            2'b01:   b = rdata[15:8];
            2'b10:   b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = lane[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b100:  fmt_load = {24'b0, b};
            3'b101:  fmt_load = {16'b0, h};
            default: fmt_load = rdata;
        endcase
    endfunction

    assign accept  = req_valid && req_ready;
    assign acc_err = check_req(req_we, req_funct3, req_addr);

    // Request capture stage: data registers only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_p0     <= req_we;
            funct3_p0 <= req_funct3;
            addr_p0   <= req_addr;
            wdata_p0  <= req_wdata;
        end
    end

    // Control state, latency counter and response registers.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_rdata <= '0;
            rsp_err   <= ERR_OK;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt <= req_we ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
                        if (acc_err != ERR_OK) begin
                            rsp_rdata <= '0;
                            rsp_err   <= acc_err;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt - CNT_W'(1);
                    if ((cnt == CNT_W'(1)) && we_p0) begin
                        rsp_rdata <= '0;
                        rsp_err   <= ERR_OK;
                    end
                end
                CAPTURE: begin
                    rsp_rdata <= fmt_load(funct3_p0, addr_p0[1:0], mem_rdata);
                    rsp_err   <= ERR_OK;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = (acc_err != ERR_OK) ? RESP : ACCESS;
            end
            ACCESS: begin
                if (cnt == CNT_W'(1))
                    state_nxt = we_p0 ? RESP : CAPTURE;
            end
            CAPTURE: state_nxt = RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE) && !nrst;
        rsp_valid = (state == RESP);
        busy      = (state != IDLE);
        mem_op    = OP_IDLE;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_stall = 1'b1;
        if ((state == ACCESS) || (state == CAPTURE)) begin
            mem_op    = map_op(we_p0, funct3_p0);
            mem_addr  = addr_p0;
            mem_wdata = wdata_p0;
            mem_stall = 1'b0;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;

    localparam int RD_LAT = 3;
    localparam int WR_LAT = 3;

    logic        clk;
    logic        nrst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [13:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_err;
    logic        busy;
    logic [2:0]  mem_op;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_stall;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    // Next request presented while the current one is in flight.
    logic        nxt_we;
    logic [2:0]  nxt_f3;
    logic [13:0] nxt_addr;
    logic [31:0] nxt_wdata;

    lsu_ctrl #(.RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .nrst(nrst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .busy(busy), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_stall(mem_stall), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [1:0] m_err(input logic we, input logic [2:0] f3,
                                         input logic [13:0] addr);
        bit legal;
        int sz;
        int region;
        if (we) legal = (f3 <= 3'd2);
        else    legal = !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
        if (!legal) return 2'd3;
        sz = 1 << int'(f3[1:0]);
        if ((int'(addr) % sz) != 0) return 2'd1;
        region = (int'(addr) / 1024) % 4;
        if (region != 1 && region != 2) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [2:0] m_op(input logic we, input logic [2:0] f3);
        if (we) return (f3 == 3'd0) ? 3'd4 : (f3 == 3'd1) ? 3'd5 : 3'd7;
        return (f3 == 3'd0) ? 3'd0 : (f3 == 3'd1) ? 3'd1 : 3'd2;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [13:0] addr,
                                           input logic [31:0] rdata);
        int a;
        a = int'(addr);
        if (f3 == 3'd4) return (rdata >> (8 * (a % 4))) & 32'h0000_00FF;
        if (f3 == 3'd5) return (rdata >> (16 * ((a / 2) % 2))) & 32'h0000_FFFF;
        return rdata;
    endfunction

    // Issue one request and follow it cycle by cycle to one idle cycle past
    // the response. Entered and left mid-cycle (after the falling edge).
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [13:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input bit hold_next);
        logic [1:0]  e_err;
        logic [2:0]  e_op;
        logic [31:0] e_rdata;
        int          resp_k;
        bit          got;
        bit          active;
        logic [50:0] exp_mem;
        logic [2:0]  exp_ctl;
        e_err   = m_err(we, f3, addr);
        e_op    = m_op(we, f3);
        resp_k  = (e_err != 2'd0) ? 1 : (we ? WR_LAT + 1 : RD_LAT + 2);
        e_rdata = (e_err != 2'd0 || we) ? 32'd0 : m_load(f3, addr, rdata);

        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        got = 1'b0;
        for (int w = 0; w < 20 && !got; w++) begin
            #1;
            if (req_ready === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept_timeout: req_ready=%b required 1 within 20 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (hold_next) begin
            req_we = nxt_we; req_funct3 = nxt_f3; req_addr = nxt_addr; req_wdata = nxt_wdata;
        end else begin
            req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
            req_addr = 14'($urandom); req_wdata = $urandom;
        end

        for (int k = 1; k <= resp_k + 1; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            mem_rdata = (!we && e_err == 2'd0 && k == RD_LAT + 1) ? rdata : $urandom;
            @(negedge clk);
            active  = (e_err == 2'd0) && (k < resp_k);
            exp_mem = active ? {e_op, addr, wdata, 1'b0} : {3'b011, 14'd0, 32'd0, 1'b1};
            exp_ctl = {k <= resp_k, k == resp_k, k > resp_k};
            n_tests++;
            if ({mem_op, mem_addr, mem_wdata, mem_stall} !== exp_mem) begin
                n_fail++;
                $display("FAIL mem_port k=%0d op/addr/wdata/stall got %h/%h/%h/%b required %h/%h/%h/%b",
                         k, mem_op, mem_addr, mem_wdata, mem_stall,
                         exp_mem[50:48], exp_mem[47:34], exp_mem[33:2], exp_mem[0]);
            end
            n_tests++;
            if ({busy, rsp_valid, req_ready} !== exp_ctl) begin
                n_fail++;
                $display("FAIL ctrl k=%0d busy/rsp_valid/req_ready got %b required %b",
                         k, {busy, rsp_valid, req_ready}, exp_ctl);
            end
            if (k >= resp_k) begin
                n_tests++;
                if ({rsp_rdata, rsp_err} !== {e_rdata, e_err}) begin
                    n_fail++;
                    $display("FAIL rsp k=%0d rdata/err got %h/%b required %h/%b",
                             k, rsp_rdata, rsp_err, e_rdata, e_err);
                end
            end
        end
    endtask

    task automatic test_reset();
        nrst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, rsp_valid, req_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl busy/rsp_valid/req_ready got %b required 000",
                     {busy, rsp_valid, req_ready});
        end
        n_tests++;
        if ({mem_op, mem_addr, mem_wdata, mem_stall} !== {3'b011, 14'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_mem op/addr/wdata/stall got %h/%h/%h/%b required 3/0/0/1",
                     mem_op, mem_addr, mem_wdata, mem_stall);
        end
        n_tests++;
        if ({rsp_rdata, rsp_err} !== 34'd0) begin
            n_fail++;
            $display("FAIL reset_rsp rdata/err got %h/%b required 0/00", rsp_rdata, rsp_err);
        end
        nrst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_reset got %b required 1", req_ready);
        end
    endtask

    task automatic test_load_word();
        run_txn(1'b0, 3'b010, 14'h0404, 32'h5555_AAAA, 32'h8000_00F0, 1'b0);
    endtask

    task automatic test_load_byte_half();
        run_txn(1'b0, 3'b100, 14'h0407, 32'd0, 32'hF122_3344, 1'b0);  // LBU
        run_txn(1'b0, 3'b000, 14'h0407, 32'd0, 32'hF122_3344, 1'b0);  // LB
        run_txn(1'b0, 3'b101, 14'h0806, 32'd0, 32'h9ABC_DEF0, 1'b0);  // LHU upper
        run_txn(1'b0, 3'b101, 14'h0804, 32'd0, 32'h9ABC_DEF0, 1'b0);  // LHU lower
        run_txn(1'b0, 3'b100, 14'h0401, 32'd0, 32'h1122_8844, 1'b0);  // LBU lane 1
    endtask

    task automatic test_store();
        run_txn(1'b1, 3'b001, 14'h0802, 32'h1234_ABCD, 32'd0, 1'b0);  // SH
        run_txn(1'b1, 3'b000, 14'h0BFF, 32'h0000_00EE, 32'd0, 1'b0);  // SB
        run_txn(1'b1, 3'b010, 14'h07FC, 32'hCAFE_F00D, 32'd0, 1'b0);  // SW
    endtask

    task automatic test_errors();
        run_txn(1'b0, 3'b010, 14'h0406, 32'd0, 32'hFFFF_FFFF, 1'b0);  // misaligned
        run_txn(1'b0, 3'b001, 14'h0C00, 32'd0, 32'hFFFF_FFFF, 1'b0);  // unmapped
        run_txn(1'b1, 3'b100, 14'h0400, 32'h1, 32'd0, 1'b0);         // illegal store funct3
        run_txn(1'b1, 3'b101, 14'h0001, 32'h1, 32'd0, 1'b0);         // funct3 beats the rest
        run_txn(1'b0, 3'b010, 14'h0C02, 32'd0, 32'd0, 1'b0);         // misalign beats map
        run_txn(1'b0, 3'b111, 14'h0400, 32'd0, 32'd0, 1'b0);         // illegal load funct3
    endtask

    task automatic test_back_to_back();
        nxt_we = 1'b1; nxt_f3 = 3'b010; nxt_addr = 14'h0808; nxt_wdata = 32'hDEAD_BEEF;
        run_txn(1'b0, 3'b010, 14'h0500, 32'd0, 32'h0BAD_F00D, 1'b1);
        nxt_we = 1'b0; nxt_f3 = 3'b101; nxt_addr = 14'h0902; nxt_wdata = 32'd0;
        run_txn(1'b1, 3'b010, 14'h0808, 32'hDEAD_BEEF, 32'd0, 1'b1);
        run_txn(1'b0, 3'b101, 14'h0902, 32'd0, 32'h7654_3210, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_txn(1'b1, 3'b111, 14'h0400, 32'd0, 32'd0, 1'b0);  // leaves rsp_err=11
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 14'h0404; req_wdata = 32'h1357_9BDF;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset_ready got %b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({req_ready, mem_op} !== {1'b0, 3'b010}) begin
            n_fail++;
            $display("FAIL mid_reset_pre req_ready/mem_op got %b/%h required 0/2", req_ready, mem_op);
        end
        @(posedge clk); #1;
        nrst = 1'b0;
        n_tests++;
        if ({busy, rsp_valid, mem_op, mem_addr, mem_wdata, mem_stall, rsp_rdata, rsp_err}
            !== {1'b0, 1'b0, 3'b011, 14'd0, 32'd0, 1'b1, 32'd0, 2'b00}) begin
            n_fail++;
            $display("FAIL mid_reset_state busy/rv/op/addr/wd/stall/rdata/err got %b/%b/%h/%h/%h/%b/%h/%b required 0/0/3/0/0/1/0/00",
                     busy, rsp_valid, mem_op, mem_addr, mem_wdata, mem_stall, rsp_rdata, rsp_err);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if ({busy, rsp_valid, req_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL mid_reset_after k=%0d busy/rsp_valid/req_ready got %b required 001",
                         k, {busy, rsp_valid, req_ready});
            end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [2:0]  f3;
        logic [13:0] addr;
        for (int i = 0; i < 60; i++) begin
            we   = 1'($urandom);
            f3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) :
                   (we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5)));
            addr = 14'($urandom);
            if ($urandom_range(0, 2) != 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 3) != 0) addr[11:10] = 2'($urandom_range(1, 2));
            run_txn(we, f3, addr, $urandom, $urandom, 1'b0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_load_byte_half();
        test_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit controller sitting in the core's MEM stage, acting as the initiator toward the data-memory block (op_code/rwaddr/wdata/rdata port). Accepts one RISC-V load or store per handshake, decodes funct3 into the memory op encoding, checks alignment and address map, holds the memory request stable for the memory's pipeline latency, and returns a formatted load result (including LBU/LHU zero-extension, which the memory cannot do). Raises `busy` so the pipeline stalls for the duration of each access.

## Interface
- RD_LAT, 3: cycles a load op/address is held before read data is valid at `mem_rdata`.
- WR_LAT, 3: cycles a store op/address/data is held to complete the write.
- clk  in  1  clock.
- nrst  in  1  reset; synchronous, active-high (1 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE and not in reset; transfer on valid&ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
- req_addr  in  14  byte address.
- req_wdata  in  32  store data, right-aligned.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  load result (0 for stores/errors).
- rsp_err  out  2  00 ok, 01 misaligned, 10 unmapped, 11 illegal funct3.
- busy  out  1  high from accept until the cycle after RESP.
- mem_op  out  3  memory op_code: 000 LB, 001 LH, 010 LW, 100 SB, 101 SH, 111 SW, 011 idle.
- mem_addr  out  14  memory rwaddr.
- mem_wdata  out  32  memory wdata (raw, memory does lane placement).
- mem_stall  out  1  memory stall; 1 whenever no access is active.
- mem_rdata  in  32  memory rdata.

## Operation
- States: IDLE, ACCESS, CAPTURE, RESP.
- IDLE: on valid&ready, register we/funct3/addr/wdata; run checks in priority order: illegal funct3 (load: 011/110/111; store: anything but 000/001/010) -> 11; misaligned (H/HU/SH addr[0]=1; W/SW addr[1:0]≠0) -> 01; unmapped (addr[11:10] not 01 or 10) -> 10. Error -> RESP directly, no memory op issued. Otherwise -> ACCESS, counter loaded with RD_LAT (load) or WR_LAT (store).
- Op mapping: LB->000, LH->001, LW->010, LBU/LHU->010 (word read, extracted locally), SB->100, SH->101, SW->111.
- ACCESS: mem_op/mem_addr/mem_wdata driven from registers, mem_stall=0; counter decrements; at 1: load -> CAPTURE, store -> RESP.
- CAPTURE (loads only): op still held, mem_stall=0; rsp_rdata registered from mem_rdata: LB/LH/LW pass through; LBU -> zero-extend byte addr[1:0]; LHU -> zero-extend half addr[1].
- RESP: rsp_valid=1 one cycle, mem_op=011, mem_stall=1 -> IDLE.
- Requests while not IDLE ignored (req_ready=0); upstream holds.
- Outside ACCESS/CAPTURE: mem_op=011, mem_addr=0, mem_wdata=0, mem_stall=1.
- rsp_rdata/rsp_err hold until next RESP; rsp_rdata cleared to 0 on store or error RESP.

## Timing
- Reset (nrst=1 at an edge): state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=00, busy=0, mem_op=011, mem_addr=0, mem_wdata=0, mem_stall=1; req_ready=0 while nrst=1.
- Reset mid-access: next edge forces IDLE, no rsp_valid, memory op dropped (store may be partial; owner's responsibility).
- Accept at edge T: load ACCESS T+1..T+RD_LAT, CAPTURE T+RD_LAT+1, rsp_valid T+RD_LAT+2 (default T+5); store ACCESS T+1..T+WR_LAT, rsp_valid T+WR_LAT+1 (default T+4); error rsp_valid T+1.
- req_ready high again the cycle after RESP; back-to-back throughput = latency+1 cycles.
- busy high T+1 through RESP inclusive.
- mem_addr/mem_op constant across all ACCESS and CAPTURE cycles of one request.

## Test plan
- Reset then LW addr 0x0404, mem_rdata=0x8000_00F0 during CAPTURE -> mem_op=010 cycles T+1..T+4, rsp_valid at T+5, rsp_rdata=0x8000_00F0, rsp_err=00.
- LBU addr 0x0407, mem_rdata=0xF1_22_33_44 -> mem_op=010, rsp_rdata=0x0000_00F1; LB same addr -> mem_op=000, result from memory passed through.
- SH addr 0x0802 wdata 0x1234_ABCD -> mem_op=101, mem_addr=0x0802, mem_wdata=0x1234_ABCD, mem_stall=0 for 3 cycles, rsp_valid at T+4, rsp_rdata=0.
- LW addr 0x0406 -> rsp_err=01 at T+1, mem_op stays 011; LH addr 0x0C00 -> rsp_err=10; store funct3=100 -> rsp_err=11.
- Second req_valid held during busy -> not accepted until cycle after RESP; then accepted with correct data.
- nrst asserted at T+2 of a load -> IDLE next edge, no rsp_valid, all outputs at reset values.
